// File: rtl/uart_tx_scheduler_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit scheduler.
//   tx_state_e         frame sequencer states
//   DEFAULT_DATA_BITS  default data bits per frame
//   DEFAULT_STOP_BITS  default stop bit periods per frame
//   onehot_to_idx()    index of the set bit of a one-hot vector (up to MAX_REQ bits)
package uart_pkg;

    localparam int MAX_REQ           = 8;
    localparam int IDX_W             = 3;
    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        STOP
    } tx_state_e;

    // OR of the indices of all set bits; exact for a one-hot or all-zero input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester-side and line-side signals of the scheduler.
//   req_valid  [N_REQ]            per-requester byte valid
//   req_data   [N_REQ*DATA_BITS]  per-requester byte, slice i*DATA_BITS +: DATA_BITS
//   req_ready  [N_REQ]            one-hot accept
//   tx                            serial line, idle high
//   busy                          frame in progress
//   grant_id   [ID_W]             owner of the current or most recent frame
//   frame_done                    one-clk pulse when the last stop bit ends
// master: requester/pad side; slave: the scheduler.
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int ID_W      = $clog2(N_REQ)
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*DATA_BITS-1:0] req_data;
    logic [N_REQ-1:0]           req_ready;
    logic                       tx;
    logic                       busy;
    logic [ID_W-1:0]            grant_id;
    logic                       frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx, busy, grant_id, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx, busy, grant_id, frame_done
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   [N_REQ]  request vector
//   last  [ID_W]   index of the previous winner; search starts at last+1
//   en             grant enable; gnt is all-zero when low
//   gnt   [N_REQ]  one-hot grant
//   idx   [ID_W]   index of the granted request
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);
    logic          found;
    logic [ID_W:0] pos;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            // last+k wrapped once into 0..N_REQ-1
            pos = {1'b0, last} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N_REQ)) pos = pos - (ID_W+1)'(N_REQ);
            if (en && !found && req[pos[ID_W-1:0]]) begin
                gnt[pos[ID_W-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
        idx = ID_W'(onehot_to_idx(MAX_REQ'(gnt)));
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART tx line between N_REQ
// byte requesters; each accepted byte is sent as start, DATA_BITS data (LSB
// first), STOP_BITS stop bits, paced by baud_tick.
//   clk, rst   clock; asynchronous active-high reset
//   baud_tick  one-clk pulse per bit period
//   bus        uart_tx_scheduler_if.slave (requests, tx, busy, grant_id, frame_done)
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int STOP_BITS = DEFAULT_STOP_BITS,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               baud_tick,
    uart_tx_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    tx_state_e            state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic                 stop_q, stop_d;

    logic [N_REQ-1:0]     gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 arb_en;
    logic [DATA_BITS-1:0] cap_byte;

    // No accept during the frame_done cycle: the next frame starts one cycle later.
    assign arb_en = (state_q == IDLE) && !done_q;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req  (bus.req_valid),
        .last (last_q),
        .en   (arb_en),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    always_comb begin
        cap_byte = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) cap_byte = bus.req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        grant_d  = grant_q;
        last_d   = last_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        stop_d   = stop_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (|gnt) begin
                    shift_d = cap_byte;
                    grant_d = gnt_idx;
                    last_d  = gnt_idx;
                    busy_d  = 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d     = shift_q[0];
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    // tx takes the bit that becomes shift[0] after this shift
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(DATA_BITS - 1)) begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            grant_q  <= '0;
            last_q   <= ID_W'(N_REQ - 1);
            shift_q  <= '0;
            bitcnt_q <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            stop_q   <= stop_d;
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (8N1 and 7 data / 2 stop) driven
// with directed and random requests; a tick-counting frame model predicts
// every output on every cycle, plus literal waveform and grant-order pins.
module tb_uart_tx_scheduler;
    localparam int N = 4;

    logic clk;
    logic rst;
    logic baud_tick;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_REQ(N), .DATA_BITS(8)) ifa ();
    uart_tx_scheduler_if #(.N_REQ(N), .DATA_BITS(7)) ifb ();

    uart_tx_scheduler #(.N_REQ(N), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(ifa)
    );
    uart_tx_scheduler #(.N_REQ(N), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(ifb)
    );

    // stimulus
    logic [N-1:0] vld [2];
    logic [7:0]   byt [2][N];
    bit           hold_mode;
    int           tph;

    always_comb begin
        ifa.req_valid = vld[0];
        ifb.req_valid = vld[1];
        ifa.req_data  = '0;
        ifb.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            ifa.req_data[i*8 +: 8] = byt[0][i];
            ifb.req_data[i*7 +: 7] = byt[1][i][6:0];
        end
    end

    // model: per instance, frame active flag and ticks counted since accept
    bit           m_act  [2];
    bit           m_done [2];
    int           m_k    [2];
    int           m_last [2];
    int           m_gid  [2];
    logic [7:0]   m_byte [2];
    logic [N-1:0] acc    [2];

    int n_chk, n_pass;
    bit chk_on;
    bit capa[$], capb[$];
    int ga[$], gb[$];

    function automatic int db_of(int d); return (d == 0) ? 8 : 7; endfunction
    function automatic int sb_of(int d); return (d == 0) ? 1 : 2; endfunction

    function automatic logic [N-1:0] exp_ready(int d);
        logic [N-1:0] r;
        r = '0;
        if (!m_act[d] && !m_done[d]) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last[d] + k) % N;
                if (vld[d][j] && r == '0) r[j] = 1'b1;
            end
        end
        return r;
    endfunction

    // tick 0: align (1), tick 1: start (0), ticks 2..DB+1: data, then stop (1)
    function automatic logic exp_tx(int d);
        int k;
        k = m_k[d];
        if (!m_act[d] || k == 0) return 1'b1;
        if (k == 1) return 1'b0;
        if (k <= db_of(d) + 1) return m_byte[d][k-2];
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d]  = 1'b0;
            m_done[d] = 1'b0;
            m_k[d]    = 0;
            m_last[d] = N - 1;
            m_gid[d]  = 0;
            m_byte[d] = '0;
            acc[d]    = '0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [N-1:0] r;
                r         = exp_ready(d);
                acc[d]    = r;
                m_done[d] = 1'b0;
                if (m_act[d]) begin
                    if (baud_tick) begin
                        m_k[d]++;
                        if (m_k[d] == db_of(d) + sb_of(d) + 2) begin
                            m_act[d]  = 1'b0;
                            m_done[d] = 1'b1;
                        end
                    end
                end else if (r != '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (r[i]) begin
                            m_gid[d]  = i;
                            m_last[d] = i;
                            m_byte[d] = byt[d][i];
                        end
                    end
                    m_act[d] = 1'b1;
                    m_k[d]   = 0;
                end
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (!hold_mode) begin
            for (int d = 0; d < 2; d++) vld[d] = vld[d] & ~acc[d];
        end
        baud_tick = (tph == 3);
        tph       = (tph + 1) % 4;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while ((vld[0] != '0 || vld[1] != '0 || m_act[0] || m_act[1] || m_done[0] || m_done[1] ||
                ifa.busy || ifb.busy) && n < budget) begin
            cyc();
            n++;
        end
        cmp({nm, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    // pat: one char per bit period from the start bit on; want_ws < 0 accepts any partial align
    task automatic check_wave(input int d, input string pat, input int want_ws, input string nm);
        bit q[$];
        int ws, bad;
        if (d == 0) q = capa; else q = capb;
        ws = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] == 1'b0 && ws < 0) ws = i;
        end
        if (want_ws < 0) cmp({nm, "_align"}, 32'(ws >= 1 && ws <= 4), 32'd1);
        else             cmp({nm, "_align"}, 32'(ws), 32'(want_ws));
        cmp({nm, "_len"}, 32'(q.size() - ws), 32'(4 * pat.len()));
        bad = 0;
        if (ws >= 0 && q.size() - ws == 4 * pat.len()) begin
            for (int p = 0; p < pat.len(); p++) begin
                for (int c = 0; c < 4; c++) begin
                    if (q[ws + 4*p + c] != (pat.getc(p) == 8'h31)) bad++;
                end
            end
        end else begin
            bad = -1;
        end
        cmp({nm, "_bits"}, 32'(bad), 32'd0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("a_tx",    32'(ifa.tx),         32'(exp_tx(0)));
            cmp("a_busy",  32'(ifa.busy),       32'(m_act[0]));
            cmp("a_gid",   32'(ifa.grant_id),   32'(m_gid[0]));
            cmp("a_done",  32'(ifa.frame_done), 32'(m_done[0]));
            cmp("a_ready", 32'(ifa.req_ready),  32'(exp_ready(0)));
            cmp("b_tx",    32'(ifb.tx),         32'(exp_tx(1)));
            cmp("b_busy",  32'(ifb.busy),       32'(m_act[1]));
            cmp("b_gid",   32'(ifb.grant_id),   32'(m_gid[1]));
            cmp("b_done",  32'(ifb.frame_done), 32'(m_done[1]));
            cmp("b_ready", 32'(ifb.req_ready),  32'(exp_ready(1)));
        end
        if (!rst) begin
            if (ifa.busy) capa.push_back(ifa.tx);
            if (ifb.busy) capb.push_back(ifb.tx);
            if (ifa.frame_done) ga.push_back(int'(ifa.grant_id));
            if (ifb.frame_done) gb.push_back(int'(ifb.grant_id));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nd;
        rst = 1'b1; baud_tick = 1'b0; tph = 0; hold_mode = 1'b0;
        n_chk = 0; n_pass = 0;
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0;
            for (int i = 0; i < N; i++) byt[d][i] = '0;
        end
        model_reset();
        chk_on = 1'b1;
        repeat (3) cyc();
        cmp("reset_tx",    32'(ifa.tx),         32'd1);
        cmp("reset_busy",  32'(ifa.busy),       32'd0);
        cmp("reset_gid",   32'(ifa.grant_id),   32'd0);
        cmp("reset_done",  32'(ifa.frame_done), 32'd0);
        rst = 1'b0;
        repeat (2) cyc();

        // single byte: A sends 0xA5, B sends 0x55 (7 data, 2 stop)
        capa.delete(); capb.delete(); ga.delete(); gb.delete();
        vld[0][0] = 1'b1; byt[0][0] = 8'hA5;
        vld[1][0] = 1'b1; byt[1][0] = 8'h55;
        wait_idle(200, "s1");
        check_wave(0, "0101001011", -1, "s1");
        check_wave(1, "0101010111", -1, "s6");
        cmp("s1_done_cnt", 32'(ga.size()), 32'd1);
        cmp("s1_gid", 32'(ga.size() > 0 ? ga[0] : -1), 32'd0);
        cmp("s6_done_cnt", 32'(gb.size()), 32'd1);

        // accept coincident with a baud tick: align must last a full 4 clk
        n = 0;
        do begin cyc(); n++; end while (!baud_tick && n < 8);
        capa.delete();
        vld[0][2] = 1'b1; byt[0][2] = 8'h3C;
        wait_idle(200, "s4");
        check_wave(0, "0001111001", 4, "s4");

        // reset in the middle of data bit 4 (0xC3: bit 4 is 0)
        vld[0][1] = 1'b1; byt[0][1] = 8'hC3;
        n = 0;
        while (m_k[0] != 6 && n < 200) begin cyc(); n++; end
        cmp("s5_reach_bit4", 32'(n < 200), 32'd1);
        repeat (2) cyc();
        cmp("s5_pre_tx", 32'(ifa.tx), 32'd0);
        nd = ga.size();
        rst = 1'b1;
        model_reset();
        for (int d = 0; d < 2; d++) vld[d] = '0;
        #1;
        cmp("s5_async_tx",   32'(ifa.tx),   32'd1);
        cmp("s5_async_busy", 32'(ifa.busy), 32'd0);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        cmp("s5_no_done", 32'(ga.size()), 32'(nd));

        // all four at once: order 0,1,2,3 after reset
        ga.delete(); gb.delete();
        for (int d = 0; d < 2; d++) begin
            vld[d] = '1;
            for (int i = 0; i < N; i++) byt[d][i] = 8'(8'h11 * (i + 1));
        end
        wait_idle(400, "s2");
        cmp("s2_cnt_a", 32'(ga.size()), 32'd4);
        cmp("s2_cnt_b", 32'(gb.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cmp("s2_order_a", 32'(i < ga.size() ? ga[i] : -1), 32'(i));
            cmp("s2_order_b", 32'(i < gb.size() ? gb[i] : -1), 32'(i));
        end

        // requesters 1 and 3 hold valid: alternating grants
        ga.delete(); gb.delete();
        hold_mode = 1'b1;
        vld[0] = 4'b1010; vld[1] = 4'b1010;
        n = 0;
        while (ga.size() < 6 && n < 600) begin cyc(); n++; end
        cmp("s3_timeout", 32'(n < 600), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cmp("s3_order_a", 32'(i < ga.size() ? ga[i] : -1), 32'((i % 2 == 0) ? 1 : 3));
        end
        hold_mode = 1'b0;
        vld[0] = '0; vld[1] = '0;
        wait_idle(200, "s3");

        // random traffic, including withdrawn valids and data changes after accept
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (!vld[d][i]) begin
                        if ($urandom_range(0, 7) == 0) begin
                            vld[d][i] = 1'b1;
                            byt[d][i] = 8'($urandom);
                        end
                    end else if ($urandom_range(0, 63) == 0) begin
                        vld[d][i] = 1'b0;
                    end
                end
            end
        end
        vld[0] = '0; vld[1] = '0;
        wait_idle(200, "rand");

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
